// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: two single-entry write slots (A/B) arbitrated onto one register-file write port; req/addr/data/ready in, writeEn/writeReg/writeData/grant out
module rf_wr_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqA,
  input  logic [2:0]        addrA,
  input  logic [DATA_W-1:0] dataA,
  output logic              readyA,
  input  logic              reqB,
  input  logic [2:0]        addrB,
  input  logic [DATA_W-1:0] dataB,
  output logic              readyB,
  output logic              writeEn,
  output logic [2:0]        writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              grantA,
  output logic              grantB
);
  logic va, vb, last_b, older_b, acc_a, acc_b, pick_b;
  logic [2:0] aa, ab;
  logic [DATA_W-1:0] da, db;
  always_comb begin
    pick_b = (aa == ab) ? older_b : !last_b;
    grantA = !rst & va & !(vb & pick_b);
    grantB = !rst & vb & !(va & !pick_b);
    readyA = !rst & (!va | grantA);
    readyB = !rst & (!vb | grantB);
    acc_a = reqA & readyA;
    acc_b = reqB & readyB;
    writeEn = grantA | grantB;
    writeReg = grantA ? aa : grantB ? ab : '0;
    writeData = grantA ? da : grantB ? db : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      va <= 1'b0;
      vb <= 1'b0;
      last_b <= 1'b1;
      older_b <= 1'b0;
    end else begin
      va <= acc_a | (va & !grantA);
      vb <= acc_b | (vb & !grantB);
      if (acc_a) begin
        aa <= addrA;
        da <= dataA;
      end
      if (acc_b) begin
        ab <= addrB;
        db <= dataB;
      end
      if (writeEn) last_b <= grantB;
      older_b <= (acc_a & acc_b) ? 1'b0 : (acc_a & vb & !grantB) ? 1'b1 : (acc_b & va & !grantA) ? 1'b0 : older_b;
    end
  end
endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, width of the write data path.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 reqA  input  1  requester A presents a write.
REQ-005 addrA  input  3  requester A destination register.
REQ-006 dataA  input  DATA_W  requester A write data.
REQ-007 readyA  output  1  requester A slot can accept this cycle.
REQ-008 reqB, addrB, dataB, readyB  as REQ-004..007 for requester B.
REQ-009 writeEn  output  1  register-file write strobe.
REQ-010 writeReg  output  3  register-file write address.
REQ-011 writeData  output  DATA_W  register-file write data.
REQ-012 grantA, grantB  output  1 each  one-hot: which slot drives the write port this cycle.

Function
REQ-013 The block SHALL hold one slot per requester: valid bit, 3-bit address, DATA_W data.
REQ-014 A write SHALL be accepted on a rising edge when reqX and readyX are both 1; the slot loads addrX/dataX and sets valid.
REQ-015 readyX SHALL be 1 when slotX is empty or slotX is granted this cycle (back-to-back accept); otherwise 0.
REQ-016 With reqX=1 and readyX=0, the requester SHALL hold its inputs; the block SHALL ignore changes while readyX=0.
REQ-017 Latency: a write accepted on edge N SHALL appear on the write port no earlier than the cycle after edge N (not combinationally from the same cycle's inputs).
REQ-018 Each cycle with at least one valid slot, exactly one grant SHALL be asserted; with no valid slot, both grants SHALL be 0.
REQ-019 writeEn SHALL equal grantA|grantB; writeReg/writeData SHALL be the granted slot's contents; with writeEn=0 they SHALL be 0.
REQ-020 A granted slot SHALL clear valid at the end of that cycle, unless it is reloaded on the same edge per REQ-015.
REQ-021 Only one slot valid: that slot SHALL be granted.
REQ-022 Both slots valid, different addresses: round-robin; grant the slot not granted last (1-bit lastGrant register, updated on every grant).
REQ-023 Both slots valid, same address: the older slot SHALL be granted regardless of lastGrant, preserving write order to that register; lastGrant SHALL still update.
REQ-024 Age SHALL be tracked by a 1-bit olderIsB register: a slot loaded while the other is valid and not being drained is younger; if both load on the same edge, A is older.
REQ-025 Maximum sustained throughput SHALL be one register write per cycle; no grant cycle shall be lost while any slot is valid.
REQ-026 A slot SHALL never be granted twice for one accepted write, and no accepted write SHALL be dropped.

Reset
REQ-027 While rst=1: writeEn=0, grantA=grantB=0, writeReg=0, writeData=0, readyA=readyB=0.
REQ-028 On the edge with rst=1: both slots invalid, lastGrant=B (so A wins the first tie), olderIsB=0.
REQ-029 Reset asserted mid-operation SHALL discard pending slot contents without issuing their writes; requests presented during reset are not accepted.
REQ-030 The first cycle after rst deasserts SHALL show readyA=readyB=1 and writeEn=0.

Verification
REQ-031 After reset, reqA=1 addrA=3 dataA=0x1234 for one cycle -> next cycle writeEn=1 writeReg=3 writeData=0x1234 grantA=1; following cycle writeEn=0.
REQ-032 A (addr 1, 0x0001) and B (addr 2, 0x0002) accepted on the same edge -> A granted first, then B on the next cycle; readyB=0 during A's grant cycle.
REQ-033 Both requesters stream continuously to different addresses -> grants alternate A,B,A,B, with writeEn=1 every cycle and no lost or duplicated writes.
REQ-034 B accepted (addr 5, 0x00BB) while A is stalled, then A accepted (addr 5, 0x00AA) with lastGrant=A -> B written first, then A; register 5 ends at 0x00AA.
REQ-035 Both slots valid, rst pulsed for one cycle -> no writeEn during or after reset for those entries; readyA=readyB=1 on the first post-reset cycle.
REQ-036 reqA held high with changing dataA while readyA=0 -> only the value present on the accepting edge is written.
